// File: rtl/lsu_unit.sv
// Load/store unit in front of the data memory port: splits each access into one or
// two 8-byte-aligned beats, one outstanding at a time, and extends load results.
module lsu_unit #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_memop,
  input  logic              req_wen,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t              state_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                mem_req_valid_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_wen_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [7:0]          mem_wmask_q;
  logic [2:0]          off_q;
  logic [2:0]          memop_q;
  logic                wen_q;
  logic                cross_q;
  logic [7:0]          mask_hi_q;
  logic [DATA_W-1:0]   data_hi_q;
  logic [DATA_W-1:0]   rd_lo_q;

  logic [2:0]          off_d;
  logic [3:0]          size_d;
  logic [7:0]          lanes_d;
  logic [15:0]         mask16_d;
  logic [2*DATA_W-1:0] data128_d;
  logic                cross_d;
  logic                noop_d;

  always_comb begin
    off_d = req_addr[2:0];
    case (req_memop[1:0])
      2'd3:    begin lanes_d = 8'h01; size_d = 4'd1; end
      2'd2:    begin lanes_d = 8'h03; size_d = 4'd2; end
      2'd1:    begin lanes_d = 8'h0F; size_d = 4'd4; end
      default: begin lanes_d = 8'hFF; size_d = 4'd8; end
    endcase
    mask16_d  = {8'b0, lanes_d} << off_d;
    data128_d = {{DATA_W{1'b0}}, req_wdata} << {off_d, 3'b000};
    cross_d   = ({1'b0, off_d} + size_d) > 4'd8;
    noop_d    = !req_wen && (req_memop == 3'b000);
  end

  // raw holds {hi beat, lo beat}; the access starts at byte lane off of the lo beat
  function automatic logic [DATA_W-1:0] load_result(input logic [2*DATA_W-1:0] raw,
                                                    input logic [2:0] off,
                                                    input logic [2:0] memop);
    logic [DATA_W-1:0] v;
    v = DATA_W'(raw >> {off, 3'b000});
    case (memop[1:0])
      2'd3:    load_result = memop[2] ? {{56{v[7]}},  v[7:0]}  : {56'b0, v[7:0]};
      2'd2:    load_result = memop[2] ? {{48{v[15]}}, v[15:0]} : {48'b0, v[15:0]};
      2'd1:    load_result = memop[2] ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]};
      default: load_result = v;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wen_q       <= 1'b0;
      mem_wdata_q     <= '0;
      mem_wmask_q     <= '0;
      off_q           <= '0;
      memop_q         <= '0;
      wen_q           <= 1'b0;
      cross_q         <= 1'b0;
      mask_hi_q       <= '0;
      data_hi_q       <= '0;
      rd_lo_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            off_q       <= off_d;
            memop_q     <= req_memop;
            wen_q       <= req_wen;
            cross_q     <= cross_d;
            mask_hi_q   <= mask16_d[15:8];
            data_hi_q   <= data128_d[2*DATA_W-1:DATA_W];
            req_ready_q <= 1'b0;
            if (noop_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q         <= REQ0;
              mem_req_valid_q <= 1'b1;
              mem_addr_q      <= {req_addr[ADDR_W-1:3], 3'b000};
              mem_wen_q       <= req_wen;
              mem_wdata_q     <= data128_d[DATA_W-1:0];
              mem_wmask_q     <= req_wen ? mask16_d[7:0] : '0;
            end
          end
        end
        REQ0: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= WAIT0;
          end
        end
        WAIT0: begin
          if (mem_resp_valid) begin
            rd_lo_q <= mem_rdata;
            if (cross_q) begin
              state_q         <= REQ1;
              mem_req_valid_q <= 1'b1;
              mem_addr_q      <= mem_addr_q + ADDR_W'(8);
              mem_wdata_q     <= data_hi_q;
              mem_wmask_q     <= wen_q ? mask_hi_q : '0;
            end else begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= wen_q ? '0
                                    : load_result({{DATA_W{1'b0}}, mem_rdata}, off_q, memop_q);
            end
          end
        end
        REQ1: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= WAIT1;
          end
        end
        WAIT1: begin
          if (mem_resp_valid) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= wen_q ? '0 : load_result({mem_rdata, rd_lo_q}, off_q, memop_q);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;

endmodule
